// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: branch opcode/funct3 codes and the branch FIFO entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // One in-flight conditional branch, captured in ID and consumed in EX.
  typedef struct packed {
    logic               predicted;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] target;
  } br_entry_t;

endpackage

// File: rtl/branch_fifo.sv
// Generic circular FIFO with push/pop/clear and full/empty/count status.
// Latency: an entry written at edge N is visible on rdata from edge N (readable by a pop at N+1).
// Backpressure: push while full is ignored unless a pop happens in the same cycle; clear wins over both.
module branch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop) && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Next pointer/count: clear empties the FIFO, otherwise advance on accepted push/pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage beq/bne resolution against predictions queued in ID; drives mispredict/flush/redirect.
// Latency: 1 cycle from EX resolve to registered outputs. Optional stats counters under BRU_STATS_EN.
// Backpressure: stall while the in-flight FIFO is full; a mispredict discards the FIFO and same-cycle push.
module branch_resolve_unit
  import rv_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,  // must match RV_XLEN, the entry type is sized from it
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_target,
  input  logic            id_predicted,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  output logic            wrong_prediction,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            stall,
  output logic            err_overflow,
  output logic            err_underflow,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int EW = $bits(br_entry_t);

  br_entry_t              push_entry, fifo_head, head;
  logic [EW-1:0]          fifo_rdata;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   id_push, ex_resolve, actual_taken, mispredict;
  logic                   mispredict_q;
  logic [XLEN-1:0]        redirect_pc_d, redirect_pc_q;
  logic                   err_overflow_q, err_underflow_q;

  assign id_push    = id_valid && (id_opcode == OPC_BRANCH);
  assign ex_resolve = ex_valid && (ex_opcode == OPC_BRANCH) &&
                      ((ex_funct3 == F3_BEQ) || (ex_funct3 == F3_BNE));
  assign fifo_head  = br_entry_t'(fifo_rdata);

  // Build the pushed entry, evaluate the branch and pick the corrected PC.
  always_comb begin
    push_entry           = '0;
    push_entry.predicted = id_predicted;
    push_entry.pc        = id_pc;
    push_entry.target    = id_target;
    // Resolving with nothing queued behaves as a not-taken prediction at PC 0.
    head                 = fifo_empty ? '0 : fifo_head;
    actual_taken         = (ex_funct3 == F3_BEQ) ? (ex_rs1 == ex_rs2) : (ex_rs1 != ex_rs2);
    mispredict           = ex_resolve && (actual_taken != head.predicted);
    redirect_pc_d        = '0;
    if (mispredict) redirect_pc_d = actual_taken ? head.target : head.pc + XLEN'(4);
  end

  branch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (id_push),
    .pop   (ex_resolve),
    .clear (mispredict),
    .wdata (push_entry),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Registered resolve outputs and sticky protocol-error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      mispredict_q    <= mispredict;
      redirect_pc_q   <= redirect_pc_d;
      err_overflow_q  <= err_overflow_q | (id_push && fifo_full && !ex_resolve);
      err_underflow_q <= err_underflow_q | (ex_resolve && fifo_empty);
    end
  end

  assign wrong_prediction = mispredict_q;
  assign flush            = mispredict_q;
  assign redirect_valid   = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign stall            = fifo_full;
  assign err_overflow     = err_overflow_q;
  assign err_underflow    = err_underflow_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  // Saturating resolve/mispredict counters.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (ex_resolve && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
    if (mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed plan scenarios plus random traffic against a queue model.
// Latency: expectations are queued one edge ahead and popped by an independent monitor.
// Backpressure: the model tracks occupancy so stall/overflow expectations follow the FIFO depth.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [6:0] OPC = 7'b1100011;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            id_valid = 1'b0;
  logic [6:0]      id_opcode = '0;
  logic [XLEN-1:0] id_pc = '0, id_target = '0;
  logic            id_predicted = 1'b0;
  logic            ex_valid = 1'b0;
  logic [6:0]      ex_opcode = '0;
  logic [2:0]      ex_funct3 = '0;
  logic [XLEN-1:0] ex_rs1 = '0, ex_rs2 = '0;
  logic            wrong_prediction, flush, redirect_valid, stall, err_overflow, err_underflow;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     stat_branches, stat_mispredicts;

  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_pc(id_pc), .id_target(id_target),
    .id_predicted(id_predicted),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .wrong_prediction(wrong_prediction), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit        pred;
    bit [31:0] pc;
    bit [31:0] tgt;
  } ent_t;

  typedef struct packed {
    bit        mis;
    bit [31:0] rpc;
    bit        stall;
    bit        ovf;
    bit        unf;
    bit [31:0] sb;
    bit [31:0] sm;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  bit   m_ovf, m_unf;
  bit [31:0] m_sb, m_sm;
  int   errors = 0;
  int   checks = 0;
  bit   stats_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_unf = 0; m_sb = 0; m_sm = 0;
  endtask

  // Behavioural reference: a list of pending predictions, resolved oldest first.
  task automatic model_step(input bit iv, input bit [6:0] iop, input bit [31:0] ipc,
                            input bit [31:0] itg, input bit ipr, input bit ev,
                            input bit [6:0] eop, input bit [2:0] ef3,
                            input bit [31:0] r1, input bit [31:0] r2, output exp_t e);
    bit   push, res, was_full, taken, mis;
    ent_t h;
    push     = iv && (iop == OPC);
    res      = ev && (eop == OPC) && (ef3 <= 3'd1);
    was_full = (mq.size() == DEPTH);
    mis      = 0;
    e        = '0;
    if (res) begin
      if (mq.size() == 0) begin
        h     = '0;
        m_unf = 1;
      end else begin
        h = mq.pop_front();
      end
      taken = (ef3 == 3'd0) ? (r1 == r2) : (r1 != r2);
      mis   = (taken != h.pred);
      if (mis) begin
        e.rpc = taken ? h.tgt : h.pc + 32'd4;
        mq.delete();
      end
      if (stats_on && m_sb != 32'hFFFF_FFFF) m_sb++;
      if (stats_on && mis && m_sm != 32'hFFFF_FFFF) m_sm++;
    end
    if (push && !mis) begin
      if (was_full && !res) m_ovf = 1;
      else mq.push_back('{pred: ipr, pc: ipc, tgt: itg});
    end
    e.mis   = mis;
    e.stall = (mq.size() == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.sb    = m_sb;
    e.sm    = m_sm;
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show after the next edge.
  task automatic step(input bit iv, input bit [6:0] iop, input bit [31:0] ipc,
                      input bit [31:0] itg, input bit ipr, input bit ev,
                      input bit [6:0] eop, input bit [2:0] ef3,
                      input bit [31:0] r1, input bit [31:0] r2);
    exp_t e;
    @(posedge clk); #2;
    id_valid = iv; id_opcode = iop; id_pc = ipc; id_target = itg; id_predicted = ipr;
    ex_valid = ev; ex_opcode = eop; ex_funct3 = ef3; ex_rs1 = r1; ex_rs2 = r2;
    model_step(iv, iop, ipc, itg, ipr, ev, eop, ef3, r1, r2, e);
    exp_q.push_back(e);
  endtask

  task automatic push_br(input bit [31:0] pc, input bit [31:0] tgt, input bit pred);
    step(1, OPC, pc, tgt, pred, 0, 7'd0, 3'd0, 0, 0);
  endtask

  task automatic resolve(input bit [2:0] f3, input bit [31:0] r1, input bit [31:0] r2);
    step(0, 7'd0, 0, 0, 0, 1, OPC, f3, r1, r2);
  endtask

  // Idle the inputs and let the monitor consume every outstanding expectation.
  task automatic drain();
    @(posedge clk); #2;
    id_valid = 0; ex_valid = 0;
    @(posedge clk); #3;
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wrong_prediction"}, wrong_prediction, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_redirect_valid"}, redirect_valid, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_err_overflow"}, err_overflow, 0);
    chk({tag, "_err_underflow"}, err_underflow, 0);
    chk({tag, "_stat_branches"}, stat_branches, 0);
    chk({tag, "_stat_mispredicts"}, stat_mispredicts, 0);
  endtask

  // Monitor: one expectation per edge while traffic is flowing.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wrong_prediction", wrong_prediction, e.mis);
        chk("flush", flush, e.mis);
        chk("redirect_valid", redirect_valid, e.mis);
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("stall", stall, e.stall);
        chk("err_overflow", err_overflow, e.ovf);
        chk("err_underflow", err_underflow, e.unf);
        chk("stat_branches", stat_branches, e.sb);
        chk("stat_mispredicts", stat_mispredicts, e.sm);
      end
    end
  end

  initial begin
    bit [31:0] exp_sb, exp_sm;
`ifdef BRU_STATS_EN
    stats_on = 1;
`else
    stats_on = 0;
`endif
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk); reset = 0;

    // beq predicted not-taken but operands equal: redirect to target.
    push_br(32'h100, 32'h140, 0);
    resolve(3'd0, 5, 5);
    // bne predicted taken but operands equal: redirect to fall-through.
    push_br(32'h200, 32'h260, 1);
    resolve(3'd1, 7, 7);
    // beq predicted not-taken, operands differ: correct, no pulse.
    push_br(32'h300, 32'h340, 0);
    resolve(3'd0, 1, 2);
    // Fill, overflow, then push+pop while full.
    for (int i = 0; i < DEPTH; i++) push_br(32'h400 + 32'(i * 4), 32'h800, 0);
    push_br(32'h500, 32'h900, 0);
    step(1, OPC, 32'h600, 32'h900, 0, 1, OPC, 3'd0, 3, 4);
    // Push together with a mispredicting pop: the push is wrong-path.
    step(1, OPC, 32'h700, 32'hA00, 1, 1, OPC, 3'd0, 9, 9);
    // FIFO must now be empty: this resolve underflows.
    resolve(3'd0, 1, 1);
    // Funct3 outside beq/bne is not a branch.
    step(1, OPC, 32'h710, 32'hB00, 1, 1, OPC, 3'd2, 1, 1);
    resolve(3'd1, 1, 2);
    drain();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      bit [2:0] f3;
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
      step($urandom_range(0, 9) < 6,
           ($urandom_range(0, 7) != 0) ? OPC : 7'($urandom),
           $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom),
           $urandom_range(0, 9) < 4,
           ($urandom_range(0, 7) != 0) ? OPC : 7'($urandom),
           f3, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    drain();

    // Asynchronous reset mid-stream with entries queued.
    for (int i = 0; i < 3; i++) push_br(32'hC00 + 32'(i * 4), 32'hD00, 1);
    drain();
    reset = 1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk); reset = 0;
    // Nothing survived the reset: a resolve now underflows.
    resolve(3'd0, 0, 1);
    drain();

    // Statistics: 10 resolves, 3 mispredicts, after a fresh reset.
    @(negedge clk); reset = 1;
    #1; model_reset();
    @(negedge clk); reset = 0;
    for (int i = 0; i < 10; i++) begin
      push_br(32'h1000 + 32'(i * 16), 32'h2000, 0);
      if (i < 3) resolve(3'd0, 4, 4);
      else       resolve(3'd0, 4, 5);
    end
    drain();
    exp_sb = stats_on ? 32'd10 : 32'd0;
    exp_sm = stats_on ? 32'd3  : 32'd0;
    chk("stats_total_branches", stat_branches, exp_sb);
    chk("stats_total_mispredicts", stat_mispredicts, exp_sm);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
